param_cpu_core: RTL
===================

PARAM_CPU_CORE -- requirements
Module: param_cpu_core

Interface
- REQ-001 Parameter DW, default 8: datapath and register width in bits; legal range 4..32.
- REQ-002 Parameter AW, default 8: PC and instruction-address width in bits.
- REQ-003 Parameter NREG, default 8: number of general registers; legal range 2..8; 3-bit register field.
- REQ-004 clk  input  1: single clock; all state updates on rising edge.
- REQ-005 reset  input  1: synchronous, active-high reset.
- REQ-006 enable  input  1: high = core advances; low = all state frozen.
- REQ-007 imem_addr  output  AW: instruction fetch address.
- REQ-008 imem_rdata  input  16: instruction word, valid exactly one cycle after imem_addr is presented.
- REQ-009 pc  output  AW: current program counter.
- REQ-010 halted  output  1: high while in HALT.
- REQ-011 zero_flag  output  1: last ALU result == 0.
- REQ-012 carry_flag  output  1: carry-out of ADD/ADDI, or borrow of SUB.
- REQ-013 dbg_raddr  input  3: debug register select.
- REQ-014 dbg_rdata  output  DW: combinational contents of register dbg_raddr; 0 if dbg_raddr >= NREG.

Function
- REQ-015 Instruction fields: op[15:12], rd[11:9], rs[8:6], imm6[5:0].
- REQ-016 Opcodes:
  - 0 NOP; 1 ADD rd=rd+rs; 2 SUB rd=rd-rs; 3 AND; 4 OR; 5 XOR.
  - 6 LDI rd=zero-extended imm6; 7 ADDI rd=rd+sign-extended imm6.
  - 8 BEQZ: if rd==0, pc=pc+1+sext(imm6).
  - 9 JMP: pc=zext(imm6).
  - F HALT.
  - A: see REQ-031.
  - All other opcodes execute as NOP.
- REQ-017 FSM states and transitions: FETCH->DECODE->EXEC->WB->FETCH; HALT is absorbing; each instruction takes exactly 4 enabled cycles.
- REQ-018 FETCH: imem_addr=pc.
- REQ-019 DECODE: latch imem_rdata into the instruction register; read rd and rs operands.
- REQ-020 EXEC: compute ALU result and branch target; latch both.
- REQ-021 WB:
  - Write rd for ALU/LDI/ADDI ops; update flags for ALU ops only (ADD, SUB, AND, OR, XOR, ADDI).
  - Set pc to the branch target if taken, else pc+1.
  - A HALT decoded in EXEC goes to HALT instead of WB; pc is not incremented.
- REQ-022 Arithmetic modulo 2^DW; PC arithmetic modulo 2^AW (0x..FF+1 wraps to 0).
- REQ-023 Register index >= NREG: writes ignored, reads return 0.
- REQ-024 enable low in any state: state, pc, registers and flags hold; imem_addr holds its value.
- REQ-025 reset and enable asserted together: reset wins.

Reset
- REQ-026 On reset:
  - FSM=FETCH, pc=0, imem_addr=0.
  - All registers=0; zero_flag=0, carry_flag=0, halted=0.
- REQ-027 Reset applies in any state, including mid-instruction and HALT; a partially executed instruction has no architectural effect.
- REQ-028 First fetch from address 0 occurs in the cycle after reset deasserts.

Configuration
- REQ-029 Macro CPU_MUL_EN selects the opcode-A behaviour.
- REQ-030 With CPU_MUL_EN defined: opcode A = MUL rd = low DW bits of rd*rs; zero_flag updated; carry_flag = 1 if high product bits are nonzero.
- REQ-031 Without CPU_MUL_EN: opcode A executes as NOP; no multiplier is synthesised.

Structure
- REQ-032 Shared package cpu_pkg holds opcode constants, the FSM state enum and instruction-field position constants.
- REQ-033 Sub-module cpu_alu (parametrised by DW) implements the combinational ALU including the optional MUL; FSM, register file and PC logic stay in param_cpu_core.

Verification
- REQ-034 LDI r1,5; LDI r2,3; ADD r1,r2 -> dbg r1=8 at cycle 12 after reset release; zero_flag=0, carry_flag=0.
- REQ-035 LDI r3,0; LDI r1,1; SUB r3,r1 -> r3=0xFF, carry_flag=1; then SUB r3,r3 -> r3=0, zero_flag=1.
- REQ-036 BEQZ r0,+2 at address 0 with r0=0 -> next fetch address 3; JMP 0 at address 0xFF -> pc=0.
- REQ-037 enable low for 5 cycles during EXEC -> pc, registers and imem_addr unchanged; the instruction completes 1 cycle after enable returns.
- REQ-038 HALT -> halted=1, pc frozen indefinitely; reset asserted -> halted=0, pc=0 on the next edge.
- REQ-039 CPU_MUL_EN defined: r1=20, r2=13, MUL r1,r2 -> r1=0x04, carry_flag=1; without CPU_MUL_EN -> r1 stays 20.

Source files
------------

// File: rtl/param_cpu_core_pkg.sv
// Shared definitions for param_cpu_core: opcodes, FSM states, instruction field positions.
// Optional feature macro: CPU_MUL_EN (opcode A = MUL when defined, NOP otherwise).
package cpu_pkg;

  // Opcode encodings
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field positions
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS_MSB  = 8;
  localparam int unsigned RS_LSB  = 6;
  localparam int unsigned IMM_MSB = 5;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcodes that update the ALU flags
  function automatic logic sets_flags(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: return 1'b1;
`ifdef CPU_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Opcodes that write the destination register
  function automatic logic writes_rd(input logic [3:0] op);
    return sets_flags(op) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/param_cpu_core_if.sv
// Instruction-memory fetch bus between the core (master) and memory (slave).
interface param_cpu_core_if #(
  parameter int unsigned AW = 8
);
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU for param_cpu_core; MUL present only when CPU_MUL_EN is defined.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [5:0]    imm_i,
  output logic [DW-1:0] res_c_o,
  output logic          carry_c_o
);

  logic [DW:0]   sum;
  logic [DW-1:0] imm_sext;
`ifdef CPU_MUL_EN
  logic [2*DW-1:0] prod;
`endif

  // Result and carry/borrow per opcode; non-ALU opcodes pass rd through
  always_comb begin
    res_c_o   = a_i;
    carry_c_o = 1'b0;
    sum       = '0;
    imm_sext  = DW'($signed(imm_i));
`ifdef CPU_MUL_EN
    prod      = '0;
`endif
    case (op_i)
      OP_NOP: res_c_o = a_i;
      OP_ADD: begin
        sum       = {1'b0, a_i} + {1'b0, b_i};
        res_c_o   = sum[DW-1:0];
        carry_c_o = sum[DW];
      end
      OP_SUB: begin
        sum       = {1'b0, a_i} - {1'b0, b_i};
        res_c_o   = sum[DW-1:0];
        carry_c_o = sum[DW];
      end
      OP_AND: res_c_o = a_i & b_i;
      OP_OR:  res_c_o = a_i | b_i;
      OP_XOR: res_c_o = a_i ^ b_i;
      OP_LDI: res_c_o = DW'(imm_i);
      OP_ADDI: begin
        sum       = {1'b0, a_i} + {1'b0, imm_sext};
        res_c_o   = sum[DW-1:0];
        carry_c_o = sum[DW];
      end
`ifdef CPU_MUL_EN
      OP_MUL: begin
        prod      = a_i * b_i;
        res_c_o   = prod[DW-1:0];
        carry_c_o = |prod[2*DW-1:DW];
      end
`else
      OP_MUL: res_c_o = a_i;
`endif
      default: res_c_o = a_i;
    endcase
  end

endmodule

// File: rtl/param_cpu_core.sv
// Multi-cycle parameterised CPU core: FETCH/DECODE/EXEC/WB FSM, register file and PC.
// Optional feature macro: CPU_MUL_EN (enables MUL in cpu_alu).
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 8,
  parameter int unsigned NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  param_cpu_core_if.master imem,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          zero_flag,
  output logic          carry_flag,
  input  logic [2:0]    dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  state_t        state_q;
  logic [AW-1:0] pc_q, next_pc_q, imem_addr_q;
  logic [3:0]    op_q;
  logic [2:0]    rd_q;
  logic [5:0]    imm_q;
  logic [DW-1:0] op_a_q, op_b_q, res_q;
  logic          alu_carry_q;
  logic          zero_flag_q, carry_flag_q, halted_q;
  logic [DW-1:0] regs_q [NREG];

  logic [3:0]    f_op_d;
  logic [2:0]    f_rd_d, f_rs_d;
  logic [5:0]    f_imm_d;
  logic [DW-1:0] rd_val_d, rs_val_d, alu_res_d;
  logic          alu_carry_d;
  logic [AW-1:0] pc_inc_d, br_target_d;
  logic          br_taken_d;

  assign f_op_d  = imem.imem_rdata[OP_MSB:OP_LSB];
  assign f_rd_d  = imem.imem_rdata[RD_MSB:RD_LSB];
  assign f_rs_d  = imem.imem_rdata[RS_MSB:RS_LSB];
  assign f_imm_d = imem.imem_rdata[IMM_MSB:IMM_LSB];

  assign pc_inc_d    = pc_q + AW'(1);
  assign br_target_d = pc_inc_d + AW'($signed(imm_q));
  assign br_taken_d  = (op_q == OP_BEQZ) && (op_a_q == '0);

  // Register read ports; indices with no backing register read as zero
  always_comb begin
    rd_val_d  = '0;
    rs_val_d  = '0;
    dbg_rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (f_rd_d == 3'(i))    rd_val_d  = regs_q[i];
      if (f_rs_d == 3'(i))    rs_val_d  = regs_q[i];
      if (dbg_raddr == 3'(i)) dbg_rdata = regs_q[i];
    end
  end

  cpu_alu #(.DW(DW)) u_alu (
    .op_i      (op_q),
    .a_i       (op_a_q),
    .b_i       (op_b_q),
    .imm_i     (imm_q),
    .res_c_o   (alu_res_d),
    .carry_c_o (alu_carry_d)
  );

  // Instruction sequencer, register file, flags and PC
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      next_pc_q    <= '0;
      imem_addr_q  <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      res_q        <= '0;
      alu_carry_q  <= 1'b0;
      zero_flag_q  <= 1'b0;
      carry_flag_q <= 1'b0;
      halted_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (enable) begin
      case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          op_q    <= f_op_d;
          rd_q    <= f_rd_d;
          imm_q   <= f_imm_d;
          op_a_q  <= rd_val_d;
          op_b_q  <= rs_val_d;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op_q == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            res_q       <= alu_res_d;
            alu_carry_q <= alu_carry_d;
            if (op_q == OP_JMP)  next_pc_q <= AW'(imm_q);
            else if (br_taken_d) next_pc_q <= br_target_d;
            else                 next_pc_q <= pc_inc_d;
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          for (int i = 0; i < NREG; i++) begin
            if (writes_rd(op_q) && (rd_q == 3'(i))) regs_q[i] <= res_q;
          end
          if (sets_flags(op_q)) begin
            zero_flag_q  <= (res_q == '0);
            carry_flag_q <= alu_carry_q;
          end
          pc_q        <= next_pc_q;
          imem_addr_q <= next_pc_q;
          state_q     <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign imem.imem_addr = imem_addr_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign zero_flag      = zero_flag_q;
  assign carry_flag     = carry_flag_q;

endmodule
